digit_step_counter: RTL and testbench

- Upstream feeder for the single-digit 7-segment decoder stage.
- Produces a registered BCD digit 0..9 that the decoder consumes directly.
- The digit advances either from an internal prescaler tick (auto mode) or from a debounced push-button press (manual mode).
- Also provides a wrap pulse for cascading to a tens digit.

---
 rtl/digit_step_counter.sv | 157 +++++++++++++++
 tb/tb_digit_step_counter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_step_counter.sv
// BCD digit 0..9 stepped by an internal prescaler tick (auto) or a debounced key press (manual).
// Optional macro DIGIT_DOWN_EN adds the up_n direction input (1 = count down with borrow on carry).
module digit_step_counter #(
  parameter int unsigned DIV_COUNT = 50000000,
  parameter int unsigned DB_COUNT  = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic       mode,
  input  logic       hold,
`ifdef DIGIT_DOWN_EN
  input  logic       up_n,
`endif
  output logic [3:0] digit,
  output logic       carry,
  output logic       tick
);

  localparam int unsigned PW = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
  localparam int unsigned DW = (DB_COUNT > 2) ? $clog2(DB_COUNT) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV_COUNT - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DB_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_t;

  logic [1:0]    key_sync;
  logic          key_s;
  db_state_t     db_state, db_next;
  logic [DW-1:0] db_cnt, db_cnt_next;
  logic          press;
  logic [PW-1:0] pre_cnt;
  logic          pre_term;
  logic          advance;
  logic          count_down;
  logic [3:0]    digit_next;
  logic          carry_next;

  // Two-flop synchronizer; resets to the released level so reset release never looks like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) key_sync <= '1;
    else       key_sync <= {key_sync[0], key_n};
  end

  assign key_s = key_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_state <= IDLE;
      db_cnt   <= '0;
    end else begin
      db_state <= db_next;
      db_cnt   <= db_cnt_next;
    end
  end

  always_comb begin
    db_next     = db_state;
    db_cnt_next = db_cnt;
    press       = 1'b0;
    case (db_state)
      IDLE: begin
        if (!key_s) begin
          db_next     = PRESS_WAIT;
          db_cnt_next = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          db_next = IDLE;
        end else if (db_cnt == DB_LAST) begin
          db_next = PRESSED;
          press   = 1'b1;
        end else begin
          db_cnt_next = db_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (key_s) begin
          db_next     = RELEASE_WAIT;
          db_cnt_next = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          db_next = PRESSED;
        end else if (db_cnt == DB_LAST) begin
          db_next = IDLE;
        end else begin
          db_cnt_next = db_cnt + 1'b1;
        end
      end
      default: db_next = IDLE;
    endcase
  end

  assign pre_term = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (hold) begin
      tick <= 1'b0;
    end else begin
      pre_cnt <= pre_term ? '0 : pre_cnt + 1'b1;
      tick    <= pre_term;
    end
  end

  // A press pulse seen during hold is dropped, never queued.
  assign advance = !hold && (mode ? press : pre_term);

`ifdef DIGIT_DOWN_EN
  assign count_down = up_n;
`else
  assign count_down = 1'b0;
`endif

  always_comb begin
    digit_next = digit;
    carry_next = 1'b0;
    if (advance) begin
      if (digit > 4'd9) begin
        digit_next = '0;
      end else if (count_down) begin
        if (digit == 4'd0) begin
          digit_next = 4'd9;
          carry_next = 1'b1;
        end else begin
          digit_next = digit - 4'd1;
        end
      end else if (digit == 4'd9) begin
        digit_next = '0;
        carry_next = 1'b1;
      end else begin
        digit_next = digit + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= '0;
      carry <= 1'b0;
    end else begin
      digit <= digit_next;
      carry <= carry_next;
    end
  end

endmodule

// File: tb/tb_digit_step_counter.sv
// Self-checking bench for digit_step_counter: constant vector table, hand-written key/reset
// sequences and randomized stimulus compared each cycle against a run-length reference model.
`timescale 1ns/1ps
module tb_digit_step_counter;

  localparam int unsigned DIV = 4;
  localparam int unsigned DB  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_n;
  logic       mode;
  logic       hold;
`ifdef DIGIT_DOWN_EN
  logic       up_n;
`endif
  logic [3:0] digit;
  logic       carry;
  logic       tick;

  digit_step_counter #(.DIV_COUNT(DIV), .DB_COUNT(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .key_n (key_n),
    .mode  (mode),
    .hold  (hold),
`ifdef DIGIT_DOWN_EN
    .up_n  (up_n),
`endif
    .digit (digit),
    .carry (carry),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: delayed key samples, a run length of samples disagreeing with the
  // accepted level, a count of unheld cycles, and the digit as a plain integer mod 10.
  int          m_digit;
  bit          m_carry;
  bit          m_tick;
  bit          m_sync[2];
  bit          m_level;
  int unsigned m_run;
  int unsigned m_active;

  typedef struct {
    logic        mode;
    logic        hold;
    logic        key_n;
    int unsigned cycles;
    int          exp_digit;
    int          exp_carry;
    int          exp_tick;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_digit  = 0;
    m_carry  = 1'b0;
    m_tick   = 1'b0;
    m_sync[0] = 1'b1;
    m_sync[1] = 1'b1;
    m_level  = 1'b1;
    m_run    = 0;
    m_active = 0;
  endtask

  task automatic model_edge();
    bit samp, press, term, adv, down;
    samp      = m_sync[1];
    m_sync[1] = m_sync[0];
    m_sync[0] = key_n;
    press = 1'b0;
    if (samp != m_level) begin
      m_run++;
      if (m_run == DB + 1) begin
        m_level = samp;
        m_run   = 0;
        press   = !samp;
      end
    end else begin
      m_run = 0;
    end
    term   = ((m_active % DIV) == DIV - 1);
    m_tick = !hold && term;
    adv    = !hold && (mode ? press : term);
    if (!hold) m_active++;
`ifdef DIGIT_DOWN_EN
    down = up_n;
`else
    down = 1'b0;
`endif
    m_carry = 1'b0;
    if (adv) begin
      if (down) begin
        m_carry = (m_digit == 0);
        m_digit = (m_digit + 9) % 10;
      end else begin
        m_carry = (m_digit == 9);
        m_digit = (m_digit + 1) % 10;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge();
    #1;
    check("digit", int'(digit), m_digit);
    check("carry", int'(carry), int'(m_carry));
    check("tick",  int'(tick),  int'(m_tick));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    key_n = 1'b1;
    mode  = 1'b0;
    hold  = 1'b0;
`ifdef DIGIT_DOWN_EN
    up_n  = 1'b0;
`endif
    model_reset();
    step();
    step();
    reset = 1'b0;
    check("rst_digit", int'(digit), 0);
    check("rst_carry", int'(carry), 0);
    check("rst_tick",  int'(tick),  0);
  endtask

  initial begin
    int unsigned key_left, hold_left;

    reset = 1'b1;
    key_n = 1'b1;
    mode  = 1'b0;
    hold  = 1'b0;
`ifdef DIGIT_DOWN_EN
    up_n  = 1'b0;
`endif

    // Auto count through a full wrap, then hold at 5 with prescaler frozen at 2.
    for (int i = 1; i <= 9; i++) vecs.push_back('{1'b0, 1'b0, 1'b1, 4, i, 0, 1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 4, 0, 1, 1});
    for (int i = 1; i <= 5; i++) vecs.push_back('{1'b0, 1'b0, 1'b1, 4, i, 0, 1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2, 5, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 20, 5, 0, 0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1, 5, 0, 0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1, 6, 0, 1});

    do_reset();
    for (int v = 0; v < vecs.size(); v++) begin
      mode  = vecs[v].mode;
      hold  = vecs[v].hold;
      key_n = vecs[v].key_n;
      repeat (vecs[v].cycles) step();
      check($sformatf("vec%0d_digit", v), int'(digit), vecs[v].exp_digit);
      check($sformatf("vec%0d_carry", v), int'(carry), vecs[v].exp_carry);
      check($sformatf("vec%0d_tick", v),  int'(tick),  vecs[v].exp_tick);
    end

    // Manual mode: one-cycle bounce, then a stable press with fixed latency.
    do_reset();
    mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      key_n = i[0];
      step();
    end
    check("bounce_digit", int'(digit), 0);
    key_n = 1'b0;
    repeat (5) step();
    check("press_lat5", int'(digit), 0);
    step();
    check("press_lat6", int'(digit), 1);
    repeat (50) step();
    check("held_low_digit", int'(digit), 1);

    // Bouncy release, clean second press, short release glitch.
    for (int i = 0; i < 4; i++) begin
      key_n = ~i[0];
      step();
    end
    key_n = 1'b1;
    repeat (10) step();
    check("release_digit", int'(digit), 1);
    key_n = 1'b0;
    repeat (10) step();
    check("second_press", int'(digit), 2);
    key_n = 1'b1;
    repeat (2) step();
    key_n = 1'b0;
    repeat (10) step();
    check("glitch_digit", int'(digit), 2);

    // Press completed under hold is discarded.
    key_n = 1'b1;
    repeat (10) step();
    hold  = 1'b1;
    key_n = 1'b0;
    repeat (10) step();
    hold = 1'b0;
    repeat (5) step();
    check("hold_press_discard", int'(digit), 2);

    // Async reset at digit 7 while debounce sits in PRESS_WAIT.
    do_reset();
    repeat (28) step();
    check("pre_rst_digit7", int'(digit), 7);
    key_n = 1'b0;
    repeat (3) step();
    check("pre_rst_still7", int'(digit), 7);
    #2 reset = 1'b1;
    #1;
    check("async_rst_digit", int'(digit), 0);
    check("async_rst_carry", int'(carry), 0);
    check("async_rst_tick",  int'(tick),  0);
    model_reset();
    step();
    #3 reset = 1'b0;
    repeat (3) step();
    check("post_rst_tick3", int'(tick), 0);
    step();
    check("post_rst_tick4", int'(tick), 1);
    check("post_rst_digit", int'(digit), 1);

`ifdef DIGIT_DOWN_EN
    do_reset();
    up_n = 1'b1;
    repeat (4) step();
    check("down_first_digit", int'(digit), 9);
    check("down_first_carry", int'(carry), 1);
    repeat (24) step();
    check("down_digit3", int'(digit), 3);
    up_n = 1'b0;
    repeat (4) step();
    check("dir_switch_digit", int'(digit), 4);
`endif

    // Randomized mode/hold/key activity against the model.
    do_reset();
    key_left  = 0;
    hold_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (key_left == 0) begin
        key_n    = ~key_n;
        key_left = $urandom_range(1, 8);
      end
      key_left--;
      if ($urandom_range(0, 99) < 3) mode = ~mode;
      if (hold_left == 0) begin
        hold      = ($urandom_range(0, 5) == 0);
        hold_left = $urandom_range(1, 12);
      end
      hold_left--;
`ifdef DIGIT_DOWN_EN
      if ($urandom_range(0, 99) < 2) up_n = ~up_n;
`endif
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
